// File: rtl/i2c_timing_pkg.sv
// rtl/i2c_timing_pkg.sv - shared timer state type and 50 MHz I2C interval constants
package i2c_timing_pkg;

  // Width of the interval constants below; matches the timer's default counter width
  localparam int TMR_CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tmr_state_t;

  // Intervals in 20 ns clocks: 600 ns start setup/hold, 1.3 us bus free, 400 ns generic
  localparam logic [TMR_CNT_W-1:0] T_SU_STA = 16'd30;
  localparam logic [TMR_CNT_W-1:0] T_HD_STA = 16'd30;
  localparam logic [TMR_CNT_W-1:0] T_BUF    = 16'd65;
  localparam logic [TMR_CNT_W-1:0] T_400NS  = 16'd20;

endpackage

// File: rtl/i2c_delay_timer_if.sv
// rtl/i2c_delay_timer_if.sv - control/status bundle between I2C FSM and delay timer
interface i2c_delay_timer_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
);

  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       cancel;
  logic [NUM_CH-1:0]       periodic;
  logic [NUM_CH*CNT_W-1:0] dly;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       done;

  modport master (
    output start, cancel, periodic, dly,
    input  busy, done
  );

  modport slave (
    input  start, cancel, periodic, dly,
    output busy, done
  );

endinterface

// File: rtl/i2c_delay_timer_ch.sv
// rtl/i2c_delay_timer_ch.sv - one loadable down-counting delay channel
module i2c_delay_timer_ch
  import i2c_timing_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int RETRIG = 0
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             start,
  input  logic             cancel,
  input  logic             periodic,
  input  logic [CNT_W-1:0] dly,
  output logic             busy,
  output logic             done
);

  tmr_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] reload;
  logic             per_lat;
  logic             expire;
  logic             accept;
  logic [CNT_W-1:0] load_val;

  // Expiry is decoded purely from registers so no input reaches done combinationally
  always_comb begin
    expire   = (state == RUN) && (cnt == '0);
    // A start is taken when idle, in our own expiry cycle, or at any time with retrigger
    accept   = start && ((state == IDLE) || expire || (RETRIG != 0));
    // N = 0 behaves as N = 1, so the loaded count saturates at zero
    load_val = (dly == '0) ? '0 : (dly - {{(CNT_W-1){1'b0}}, 1'b1});
  end

  // Channel FSM: reset, then cancel, then start, then count
  always_ff @(posedge CLK) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      reload  <= '0;
      per_lat <= 1'b0;
    end else if (cancel) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (accept) begin
      state   <= RUN;
      cnt     <= load_val;
      reload  <= load_val;
      per_lat <= periodic;
    end else if (state == RUN) begin
      if (cnt == '0) begin
        if (per_lat) begin
          cnt <= reload;
        end else begin
          state <= IDLE;
        end
      end else begin
        cnt <= cnt - {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign busy = (state == RUN);
  assign done = expire;

endmodule

// File: rtl/i2c_delay_timer.sv
// rtl/i2c_delay_timer.sv - multi-channel programmable delay timer for the I2C controller
module i2c_delay_timer
  import i2c_timing_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16,
  parameter int RETRIG = 0
) (
  input  logic               CLK,
  input  logic               rst,
  i2c_delay_timer_if.slave   bus
);

  // One independent channel per bit; each takes its own CNT_W slice of dly
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    i2c_delay_timer_ch #(
      .CNT_W  (CNT_W),
      .RETRIG (RETRIG)
    ) u_ch (
      .CLK      (CLK),
      .rst      (rst),
      .start    (bus.start[i]),
      .cancel   (bus.cancel[i]),
      .periodic (bus.periodic[i]),
      .dly      (bus.dly[i*CNT_W +: CNT_W]),
      .busy     (bus.busy[i]),
      .done     (bus.done[i])
    );
  end

endmodule

// File: tb/tb_i2c_delay_timer.sv
// tb/tb_i2c_delay_timer.sv - directed self-checking bench for i2c_delay_timer
module tb_i2c_delay_timer;
  import i2c_timing_pkg::*;

  localparam int NCH = 2;
  localparam int W   = 16;

  logic CLK = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #10 CLK = ~CLK;

  i2c_delay_timer_if #(.NUM_CH(NCH), .CNT_W(W)) ifa ();
  i2c_delay_timer_if #(.NUM_CH(NCH), .CNT_W(W)) ifb ();

  i2c_delay_timer #(.NUM_CH(NCH), .CNT_W(W), .RETRIG(0)) dut0 (
    .CLK (CLK),
    .rst (rst),
    .bus (ifa)
  );

  i2c_delay_timer #(.NUM_CH(NCH), .CNT_W(W), .RETRIG(1)) dut1 (
    .CLK (CLK),
    .rst (rst),
    .bus (ifb)
  );

  task automatic chk(input string tag, input int t, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0d exp=%0d", tag, t, got, exp);
    end
  endtask

  task automatic clear_inputs();
    ifa.start = '0; ifa.cancel = '0; ifa.periodic = '0; ifa.dly = '0;
    ifb.start = '0; ifb.cancel = '0; ifb.periodic = '0; ifb.dly = '0;
  endtask

  // Begin cycle t: inputs set just after the edge that opens it
  task automatic begin_cycle();
    @(posedge CLK);
    #1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    repeat (3) @(posedge CLK);
    #1 rst = 1'b1;

    // Idle after reset
    for (int t = 0; t < 50; t++) begin
      begin_cycle();
      @(negedge CLK);
      chk("rst_busy", t, {30'd0, ifa.busy}, 32'd0);
      chk("rst_done", t, {30'd0, ifa.done}, 32'd0);
    end

    // One-shot N=20 on ch0, start at cycle 10
    for (int t = 0; t <= 35; t++) begin
      begin_cycle();
      ifa.dly[W-1:0] = T_400NS;
      ifa.start[0]   = (t == 10);
      @(negedge CLK);
      chk("n20_busy", t, {31'd0, ifa.busy[0]}, {31'd0, (t >= 11 && t <= 30)});
      chk("n20_done", t, {31'd0, ifa.done[0]}, {31'd0, (t == 30)});
    end

    // N=1 and N=0 both expire one cycle after the start
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t <= 15; t++) begin
        begin_cycle();
        ifa.dly[W-1:0] = (k == 0) ? 16'd1 : 16'd0;
        ifa.start[0]   = (t == 10);
        @(negedge CLK);
        chk(k == 0 ? "n1_busy" : "n0_busy", t, {31'd0, ifa.busy[0]}, {31'd0, (t == 11)});
        chk(k == 0 ? "n1_done" : "n0_done", t, {31'd0, ifa.done[0]}, {31'd0, (t == 11)});
      end
    end

    // Periodic N=5 on ch1, cancel at 17
    for (int t = 0; t <= 25; t++) begin
      begin_cycle();
      ifa.dly[W +: W]   = 16'd5;
      ifa.periodic[1]   = 1'b1;
      ifa.start[1]      = (t == 0);
      ifa.cancel[1]     = (t == 17);
      @(negedge CLK);
      chk("per_busy", t, {31'd0, ifa.busy[1]}, {31'd0, (t >= 1 && t <= 17)});
      chk("per_done", t, {31'd0, ifa.done[1]}, {31'd0, (t == 5 || t == 10 || t == 15)});
      chk("per_ch0",  t, {31'd0, ifa.busy[0]}, 32'd0);
    end

    // Start while busy: ignored without retrigger, restarts with retrigger
    for (int t = 0; t <= 20; t++) begin
      begin_cycle();
      ifa.dly[W-1:0] = 16'd10;
      ifb.dly[W-1:0] = 16'd10;
      ifa.start[0]   = (t == 0 || t == 4);
      ifb.start[0]   = (t == 0 || t == 4);
      @(negedge CLK);
      chk("nort_busy", t, {31'd0, ifa.busy[0]}, {31'd0, (t >= 1 && t <= 10)});
      chk("nort_done", t, {31'd0, ifa.done[0]}, {31'd0, (t == 10)});
      chk("rt_busy",   t, {31'd0, ifb.busy[0]}, {31'd0, (t >= 1 && t <= 14)});
      chk("rt_done",   t, {31'd0, ifb.done[0]}, {31'd0, (t == 14)});
    end

    // Start in the done cycle with a new dly; dly change mid-run has no effect
    for (int t = 0; t <= 18; t++) begin
      begin_cycle();
      ifa.dly[W-1:0] = (t == 0) ? 16'd10 : 16'd3;
      ifa.start[0]   = (t == 0 || t == 10);
      @(negedge CLK);
      chk("dc_busy", t, {31'd0, ifa.busy[0]}, {31'd0, (t >= 1 && t <= 13)});
      chk("dc_done", t, {31'd0, ifa.done[0]}, {31'd0, (t == 10 || t == 13)});
    end

    // Start and cancel together: cancel wins
    for (int t = 0; t <= 8; t++) begin
      begin_cycle();
      ifa.dly[W-1:0] = 16'd5;
      ifa.start[0]   = (t == 0);
      ifa.cancel[0]  = (t == 0);
      @(negedge CLK);
      chk("sc_busy", t, {31'd0, ifa.busy[0]}, 32'd0);
      chk("sc_done", t, {31'd0, ifa.done[0]}, 32'd0);
    end

    // Reset held during cycles 6..8 of an N=10 run drops the pending done
    for (int t = 0; t <= 15; t++) begin
      begin_cycle();
      ifa.dly[W-1:0] = 16'd10;
      ifa.start[0]   = (t == 0);
      rst            = !(t >= 6 && t <= 8);
      @(negedge CLK);
      chk("mr_busy", t, {30'd0, ifa.busy}, {31'd0, (t >= 1 && t <= 6)});
      chk("mr_done", t, {30'd0, ifa.done}, 32'd0);
    end

    // Two channels running concurrently
    for (int t = 0; t <= 20; t++) begin
      begin_cycle();
      ifa.dly[W-1:0]  = 16'd7;
      ifa.dly[W +: W] = 16'd12;
      ifa.start[0]    = (t == 2);
      ifa.start[1]    = (t == 3);
      @(negedge CLK);
      chk("cc_done0", t, {31'd0, ifa.done[0]}, {31'd0, (t == 9)});
      chk("cc_done1", t, {31'd0, ifa.done[1]}, {31'd0, (t == 15)});
      chk("cc_busy0", t, {31'd0, ifa.busy[0]}, {31'd0, (t >= 3 && t <= 9)});
      chk("cc_busy1", t, {31'd0, ifa.busy[1]}, {31'd0, (t >= 4 && t <= 15)});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
